// File: rtl/dual_clk_pkg.sv
// dual_clk_pkg: shared FSM state type and default parameters for dual_clk_serializer
package dual_clk_pkg;
    typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;
    localparam int DEF_DATA_W    = 8;
    localparam bit DEF_MSB_FIRST = 1'b1;
    localparam bit DEF_IDLE_LVL  = 1'b1;
endpackage

// File: rtl/dual_clk_serializer_if.sv
// dual_clk_serializer_if: word handshake and status bundle of the serializer
//   tx_data/tx_valid : word offered by the master
//   tx_ready         : serializer can accept a word
//   busy/done        : word in flight / one-cycle completion pulse
interface dual_clk_serializer_if import dual_clk_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    modport master (output tx_data, tx_valid, input tx_ready, busy, done);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, done);
endinterface

// File: rtl/edge_det.sv
// edge_det: registered previous sample with rise/fall outputs
//   clk, rst_n : clock, synchronous active-low reset (history cleared to 0)
//   d_i        : sampled input
//   rise_o     : d_i is 1 and the previous sample was 0
//   fall_o     : d_i is 0 and the previous sample was 1
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic prev_q;
    always_ff @(posedge clk) prev_q <= rst_n ? d_i : 1'b0;
    assign rise_o = d_i & ~prev_q;
    assign fall_o = ~d_i & prev_q;
endmodule

// File: rtl/dual_clk_serializer.sv
// dual_clk_serializer: shifts one word out on sdo, paced by a two-phase clock generator
//   clk, rst_n     : system clock, synchronous active-low reset
//   phase0, phase1 : leading/lagging phase clocks from the generator
//   gen_en         : registered enable to the generator
//   sdo            : registered serial data, IDLE_LVL when no bit is driven
//   tx             : word handshake (tx_data, tx_valid, tx_ready) plus busy/done
module dual_clk_serializer import dual_clk_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit MSB_FIRST = DEF_MSB_FIRST,
    parameter bit IDLE_LVL  = DEF_IDLE_LVL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  phase0,
    input  logic                  phase1,
    output logic                  gen_en,
    output logic                  sdo,
    dual_clk_serializer_if.slave  tx
);
    localparam int              CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               sdo_q, sdo_d;
    logic               gen_en_q, busy_q, done_q, ready_q;
    logic               p0_rise, p1_fall, p0_fall_unused, p1_rise_unused;
    logic               next_bit;
    logic [DATA_W-1:0]  shifted;

    edge_det u_p0 (.clk(clk), .rst_n(rst_n), .d_i(phase0), .rise_o(p0_rise), .fall_o(p0_fall_unused));
    edge_det u_p1 (.clk(clk), .rst_n(rst_n), .d_i(phase1), .rise_o(p1_rise_unused), .fall_o(p1_fall));

    assign next_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign shifted  = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sdo_d   = sdo_q;
        case (state_q)
            IDLE: if (tx.tx_valid && ready_q) begin
                state_d = START;
                shreg_d = tx.tx_data;
                cnt_d   = '0;
            end
            START: if (p0_rise) begin
                state_d = SHIFT;
                sdo_d   = next_bit;
                shreg_d = shifted;
                cnt_d   = CNT_W'(1);
            end
            SHIFT: begin
                // the two conditions are exclusive through the count, so a
                // simultaneous phase0 rise and phase1 fall never collide
                if (p0_rise && cnt_q < CNT_MAX) begin
                    sdo_d   = next_bit;
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                if (p1_fall && cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    sdo_d   = IDLE_LVL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // status outputs are registered copies decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            sdo_q    <= IDLE_LVL;
            gen_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            sdo_q    <= sdo_d;
            gen_en_q <= state_d == START || state_d == SHIFT;
            busy_q   <= state_d != IDLE;
            done_q   <= state_d == DONE;
            ready_q  <= state_d == IDLE;
        end
    end

    assign gen_en      = gen_en_q;
    assign sdo         = sdo_q;
    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
endmodule

// File: tb/tb_dual_clk_serializer.sv
// tb_dual_clk_serializer: directed vectors for MSB-first and LSB-first serializers fed by one two-phase generator
module tb_dual_clk_serializer;
    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_m;
        logic [7:0] seq_l;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [2:0] gcnt = 3'd0;
    logic       phase0 = 1'b0;
    logic       phase1 = 1'b0;
    logic       gen_en_m, gen_en_l, sdo_m, sdo_l;
    int         checks = 0;
    int         errors = 0;

    dual_clk_serializer_if #(.DATA_W(8)) if_m ();
    dual_clk_serializer_if #(.DATA_W(8)) if_l ();
    assign if_m.tx_data  = tx_data;
    assign if_m.tx_valid = tx_valid;
    assign if_l.tx_data  = tx_data;
    assign if_l.tx_valid = tx_valid;

    dual_clk_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .phase0(phase0), .phase1(phase1),
        .gen_en(gen_en_m), .sdo(sdo_m), .tx(if_m));
    dual_clk_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .phase0(phase0), .phase1(phase1),
        .gen_en(gen_en_l), .sdo(sdo_l), .tx(if_l));

    always #5 clk = ~clk;

    // upstream generator, CLK_DIV=4: phase0 high 4 clks, then phase1 high 4 clks
    always_ff @(posedge clk) begin
        if (!gen_en_m) begin
            gcnt   <= 3'd0;
            phase0 <= 1'b0;
            phase1 <= 1'b0;
        end else begin
            gcnt   <= gcnt + 3'd1;
            phase0 <= gcnt < 3'd4;
            phase1 <= gcnt >= 3'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called on the sample right after acceptance; returns on the done sample
    task automatic capture(input logic [7:0] seq_m, input logic [7:0] seq_l, input bit pulse);
        logic sm [128];
        logic sl [128];
        logic [7:0] gm, gl;
        int n;
        n = 0;
        tick();
        while (!if_m.done && n < 200) begin
            if (n < 128) begin
                sm[n] = sdo_m;
                sl[n] = sdo_l;
            end
            n++;
            if (pulse && n == 20) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end else if (pulse && n == 21) tx_valid = 1'b0;
            tick();
        end
        chk("word_len", n, 65);
        if (n == 65) begin
            chk("lead_idle_m", {31'd0, sm[0]}, 1);
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    gm[j] = sm[1 + 8 * i + j];
                    gl[j] = sl[1 + 8 * i + j];
                end
                chk($sformatf("bit%0d_m", i), {24'd0, gm}, {24'd0, {8{seq_m[7 - i]}}});
                chk($sformatf("bit%0d_l", i), {24'd0, gl}, {24'd0, {8{seq_l[7 - i]}}});
            end
        end
        chk("done_m", {31'd0, if_m.done}, 1);
        chk("done_l", {31'd0, if_l.done}, 1);
        chk("done_busy", {31'd0, if_m.busy}, 1);
        chk("done_sdo", {30'd0, sdo_m, sdo_l}, 3);
        chk("done_gen_en", {30'd0, gen_en_m, gen_en_l}, 0);
    endtask

    task automatic send_word(input logic [7:0] data, input logic [7:0] seq_m, input logic [7:0] seq_l, input bit pulse);
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        chk("accept", {29'd0, if_m.busy, if_m.tx_ready, gen_en_m}, {29'd0, 3'b101});
        tx_valid = 1'b0;
        capture(seq_m, seq_l, pulse);
        tick();
        chk("after_done", {28'd0, if_m.busy, if_m.done, if_m.tx_ready, if_l.tx_ready}, {28'd0, 4'b0011});
    endtask

    initial begin
        vec_t vecs [4];
        int   cnt;
        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101};
        vecs[1] = '{8'h01, 8'b00000001, 8'b10000000};
        vecs[2] = '{8'h2D, 8'b00101101, 8'b10110100};
        vecs[3] = '{8'h80, 8'b10000000, 8'b00000001};

        tick();
        tick();
        chk("reset_state", {27'd0, if_m.tx_ready, if_m.busy, if_m.done, sdo_m, gen_en_m}, {27'd0, 5'b10010});
        chk("reset_state_l", {27'd0, if_l.tx_ready, if_l.busy, if_l.done, sdo_l, gen_en_l}, {27'd0, 5'b10010});
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) send_word(vecs[v].data, vecs[v].seq_m, vecs[v].seq_l, 1'b0);

        // back-to-back with tx_valid held high
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        chk("b2b_accept1", {30'd0, if_m.busy, if_m.tx_ready}, 2);
        capture(8'b00111100, 8'b00111100, 1'b0);
        tx_data = 8'hC3;
        tick();
        chk("b2b_gap_idle", {30'd0, if_m.busy, if_m.tx_ready}, 1);
        tick();
        chk("b2b_accept2", {30'd0, if_m.busy, if_m.tx_ready}, 2);
        tx_valid = 1'b0;
        capture(8'b11000011, 8'b11000011, 1'b0);
        tick();
        cnt = 0;
        repeat (20) begin
            tick();
            cnt += int'(if_m.busy | if_m.done);
        end
        chk("b2b_no_third", cnt, 0);

        // tx_valid pulse while busy is ignored
        send_word(8'h3C, 8'b00111100, 8'b00111100, 1'b1);
        cnt = 0;
        repeat (30) begin
            tick();
            cnt += int'(if_m.busy | if_m.done | if_l.done);
        end
        chk("ignored_pulse", cnt, 0);

        // reset in the middle of the 4th bit of F0
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (27) tick();
        chk("mid_bit4", {30'd0, sdo_m, sdo_l}, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_state", {27'd0, gen_en_m, sdo_m, if_m.tx_ready, if_m.busy, if_m.done}, {27'd0, 5'b01100});
        cnt = 0;
        repeat (80) begin
            tick();
            cnt += int'(if_m.done | if_l.done | if_m.busy);
        end
        chk("abort_no_done", cnt, 0);
        send_word(8'h0F, 8'b00001111, 8'b11110000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_clk_serializer.md
DUAL_CLK_SERIALIZER -- requirements
Module: dual_clk_serializer

Interface
REQ-001 Parameter DATA_W, default 8: width of one transmitted word.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.
REQ-003 Parameter IDLE_LVL, default 1: sdo level whenever no bit is being driven.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 phase0  input  1  leading phase clock from the upstream two-phase generator, synchronous to clk.
REQ-007 phase1  input  1  lagging phase clock from the same generator; an open-drain high is resolved to 1 externally.
REQ-008 gen_en  output  1  enable to the two-phase generator; registered.
REQ-009 tx_data  input  DATA_W  word to send; sampled only on acceptance.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  block can accept a word.
REQ-012 sdo  output  1  serial data out; registered.
REQ-013 busy  output  1  high from acceptance until done.
REQ-014 done  output  1  one-cycle pulse when a word completes.

Function
REQ-015 States: IDLE, START, SHIFT, DONE.
REQ-016 IDLE: tx_ready=1, gen_en=0, busy=0, sdo=IDLE_LVL.
REQ-017 Acceptance occurs on a clk edge with tx_valid=1 and tx_ready=1: latch tx_data into the shift register, clear the bit counter, assert gen_en and busy, and go to START.
REQ-018 tx_ready=0 in every state except IDLE; tx_valid outside IDLE is ignored and leaves no pending request.
REQ-019 Edge detection: phase0 and phase1 are registered each cycle; a rising or falling edge is the current sample differing from the registered previous sample.
REQ-020 START: remain until the first phase0 rising edge, then drive the first bit onto sdo on that same clk edge and go to SHIFT with bit count=1.
REQ-021 SHIFT: on each subsequent phase0 rising edge, drive the next bit onto sdo and increment the count while count<DATA_W.
REQ-022 In SHIFT with count==DATA_W, the next phase1 falling edge ends the word: deassert gen_en, set sdo=IDLE_LVL, and go to DONE.
REQ-023 DONE lasts exactly one cycle: done=1, busy=1; the next state is IDLE.
REQ-024 sdo changes only on a phase0 rising edge or on a state transition named above; every bit is therefore stable across the whole phase1-high window.
REQ-025 Bit counter width is clog2(DATA_W+1) and never wraps; it saturates at DATA_W.
REQ-026 A phase0 and phase1 edge in the same cycle are evaluated independently, per the rules of the current state.
REQ-027 Phase edges in IDLE or DONE are ignored.
REQ-028 Back-to-back words: a word may be accepted on the cycle after DONE; the minimum gap is 2 clk cycles (DONE plus IDLE).

Reset
REQ-029 While rst_n=0 at a clk edge: state=IDLE, gen_en=0, busy=0, done=0, sdo=IDLE_LVL, shift register=0, counter=0, phase history registers=0.
REQ-030 Reset mid-word aborts the word with no done pulse; the first cycle after release is a normal IDLE cycle.

Structure
REQ-031 A shared package dual_clk_pkg holds the state typedef (IDLE, START, SHIFT, DONE) and default parameter constants.
REQ-032 One sub-module, edge_det (registered previous sample with rise and fall outputs), is instantiated once for phase0 and once for phase1.
REQ-033 The implementation is 120-400 RTL lines, and all outputs come directly from registers.

Verification (the bench instantiates the upstream generator with CLK_DIV=4, giving an 8-clk period, wired gen_en->en)
REQ-034 Send tx_data=8'hA5 with MSB_FIRST=1 -> sdo sequence is 1,0,1,0,0,1,0,1; each bit is held 8 clk cycles; done pulses once; busy returns to 0.
REQ-035 Send tx_data=8'h01 with MSB_FIRST=0 -> the first sdo bit is 1 and the remaining 7 bits are 0; exactly 8 phase0 rising edges are consumed.
REQ-036 Hold tx_valid=1 continuously with words 8'h3C then 8'hC3 -> both words are sent; the second acceptance occurs exactly 2 cycles after the first done pulse.
REQ-037 Pulse tx_valid with 8'hFF while busy -> the pulse is ignored; there is no extra word and no extra done pulse.
REQ-038 Assert rst_n=0 for 1 cycle after the 4th bit of 8'hF0 -> next cycle gen_en=0, sdo=1, tx_ready=1, and no done pulse occurs; a following 8'h0F transmits correctly.
